// File: rtl/sc_sng_ctrl.sv
// rtl/sc_sng_ctrl.sv - stochastic number generator controller driving a bypass counter
// Emits a unipolar bitstream of 2^P bits comparing captured x against cnt; returns ones estimate.
module sc_sng_ctrl #(
  parameter int WIDTH = 8,
  parameter int PW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [PW-1:0]    prec,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt,
  input  logic             ovf,
  output logic [WIDTH-1:0] bp,
  output logic             busy,
  output logic             bit_valid,
  output logic             bit_out,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [PW-1:0] WP = PW'(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH-1:0] x_q, ones, ones_nx, mask_in, mask_q;
  logic [PW-1:0]    p_q, p_in, sh_q;

  // Out-of-range precision falls back to full width
  assign p_in    = (prec == '0 || prec > WP) ? WP : prec;
  assign mask_in = ~({WIDTH{1'b1}} << (WP - p_in));
  assign sh_q    = WP - p_q;
  assign mask_q  = ~({WIDTH{1'b1}} << sh_q);
  assign ones_nx = ones + WIDTH'(bit_out);

  always_comb begin
    state_nx  = state;
    bp        = '1;
    busy      = 1'b0;
    bit_valid = 1'b0;
    bit_out   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        bp        = mask_q;
        busy      = 1'b1;
        bit_valid = 1'b1;
        bit_out   = (x_q > cnt);
        if (ovf)        state_nx = IDLE;
        else if (abort) state_nx = DRAIN;
      end
      DRAIN: begin
        bp   = mask_q;
        busy = 1'b1;
        if (ovf) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      x_q     <= '0;
      p_q     <= '0;
      ones    <= '0;
      done    <= 1'b0;
      aborted <= 1'b0;
      result  <= '0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_q     <= x & ~mask_in;
            p_q     <= p_in;
            ones    <= '0;
            aborted <= 1'b0;
          end
        end
        RUN: begin
          ones <= ones_nx;
          // The overflow bit is the last one and must be included in the estimate
          if (ovf) begin
            done    <= 1'b1;
            aborted <= 1'b0;
            result  <= ones_nx << sh_q;
          end
        end
        DRAIN: begin
          if (ovf) begin
            done    <= 1'b1;
            aborted <= 1'b1;
            result  <= ones << sh_q;
          end
        end
        default: ;
      endcase
    end
  end

  a_idle_cnt_zero: assert property (@(posedge clk) disable iff (!rst_n)
    (state == IDLE) |-> (cnt == '0));

endmodule

// File: tb/tb_sc_sng_ctrl.sv
// tb/tb_sc_sng_ctrl.sv - directed table-driven bench for sc_sng_ctrl with a bypass counter model
module tb_sc_sng_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x = 8'h00;
  logic [3:0] prec = 4'd0;
  logic       abort = 1'b0;
  logic [7:0] cnt;
  logic       ovf;
  logic [7:0] bp;
  logic       busy, bit_valid, bit_out, done, aborted;
  logic [7:0] result;
  logic [8:0] sum;

  int n_cmp = 0;
  int n_bad = 0;

  sc_sng_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .prec(prec), .abort(abort),
    .cnt(cnt), .ovf(ovf), .bp(bp), .busy(busy), .bit_valid(bit_valid),
    .bit_out(bit_out), .done(done), .aborted(aborted), .result(result)
  );

  always #5 clk = ~clk;

  // Bypass counter: masked low bits are held at zero and carried through
  assign sum = {1'b0, cnt | bp} + 9'd1;
  assign ovf = sum[8] & (bp != 8'hFF);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 8'h00;
    else        cnt <= sum[7:0] & ~bp;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    logic [3:0] prec;
    logic [7:0] x;
    int         bits;
    int         ones;
    logic [7:0] res;
    logic [7:0] mask;
  } vec_t;

  vec_t vt[6];

  // Starts a run at the current negedge and returns at the negedge where done is seen
  task automatic run(input string tag, input logic [3:0] p, input logic [7:0] xv,
                     input int abort_at, input int glitch_at, input int exp_bits,
                     input int exp_ones, input logic [7:0] exp_res, input logic exp_ab,
                     input logic [7:0] exp_mask);
    int nbits = 0, nones = 0, lead = 0, cnt_bad = 0, bp_bad = 0;
    int last_c = -1, done_c = -1;
    bit zero_seen = 0, got_done = 0;
    int step = int'(exp_mask) + 1;
    start = 1'b1; x = xv; prec = p;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " aborted_cleared"}, int'(aborted), 0);
    for (int c = 0; c < 1000 && !got_done; c++) begin
      if (bit_valid) begin
        if (cnt !== 8'(nbits * step)) cnt_bad++;
        if (bp !== exp_mask) bp_bad++;
        nbits++;
        last_c = c;
        if (bit_out) begin
          nones++;
          if (!zero_seen) lead++;
        end else zero_seen = 1;
      end
      abort = (abort_at > 0 && bit_valid && nbits == abort_at);
      if (glitch_at > 0 && bit_valid && nbits == glitch_at) begin
        start = 1'b1; x = 8'hF0; prec = 4'd1;
      end else start = 1'b0;
      if (done) begin
        got_done = 1;
        done_c = c;
      end else @(negedge clk);
    end
    abort = 1'b0; start = 1'b0;
    chk({tag, " done_seen"}, int'(got_done), 1);
    chk({tag, " bits"}, nbits, exp_bits);
    chk({tag, " ones"}, nones, exp_ones);
    chk({tag, " leading_ones"}, lead, exp_ones);
    chk({tag, " cnt_sequence_errors"}, cnt_bad, 0);
    chk({tag, " bp_errors"}, bp_bad, 0);
    chk({tag, " result"}, int'(result), int'(exp_res));
    chk({tag, " aborted"}, int'(aborted), int'(exp_ab));
    chk({tag, " busy_at_done"}, int'(busy), 0);
    chk({tag, " cnt_at_done"}, int'(cnt), 0);
    if (!exp_ab) chk({tag, " done_latency"}, done_c - last_c, 1);
  endtask

  task automatic after_done(input string tag, input logic [7:0] exp_res, input logic exp_ab);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, int'(done), 0);
    chk({tag, " result_held"}, int'(result), int'(exp_res));
    chk({tag, " aborted_held"}, int'(aborted), int'(exp_ab));
    chk({tag, " bp_idle"}, int'(bp), 8'hFF);
  endtask

  initial begin
    vt[0] = '{4'd8, 8'hB4, 256, 180, 8'hB4, 8'h00};
    vt[1] = '{4'd4, 8'hB7, 16,  11,  8'hB0, 8'h0F};
    vt[2] = '{4'd8, 8'h00, 256, 0,   8'h00, 8'h00};
    vt[3] = '{4'd8, 8'hFF, 256, 255, 8'hFF, 8'h00};
    vt[4] = '{4'd0, 8'hB4, 256, 180, 8'hB4, 8'h00};
    vt[5] = '{4'd9, 8'h81, 256, 129, 8'h81, 8'h00};

    repeat (2) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset bit_valid", int'(bit_valid), 0);
    chk("reset done", int'(done), 0);
    chk("reset aborted", int'(aborted), 0);
    chk("reset result", int'(result), 0);
    chk("reset bp", int'(bp), 8'hFF);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle cnt frozen", int'(cnt), 0);

    for (int i = 0; i < 6; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      run(tag, vt[i].prec, vt[i].x, 0, 0, vt[i].bits, vt[i].ones, vt[i].res, 1'b0, vt[i].mask);
      after_done(tag, vt[i].res, 1'b0);
    end

    // Abort on the 10th bit, then restart in the done cycle
    run("abort", 4'd8, 8'h80, 10, 0, 10, 10, 8'd10, 1'b1, 8'h00);
    run("restart", 4'd2, 8'h40, 0, 0, 4, 1, 8'h40, 1'b0, 8'h3F);
    after_done("restart", 8'h40, 1'b0);

    // start pulsed mid-run with different operand must be ignored
    run("glitch", 4'd8, 8'h30, 0, 5, 256, 48, 8'h30, 1'b0, 8'h00);
    after_done("glitch", 8'h30, 1'b0);

    // abort in IDLE has no effect
    abort = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_abort busy", int'(busy), 0);
      chk("idle_abort done", int'(done), 0);
    end
    abort = 1'b0;
    chk("idle_abort result", int'(result), 8'h30);

    // Asynchronous reset mid-run at cnt=0x37
    begin
      bit hit = 0;
      start = 1'b1; x = 8'h80; prec = 4'd8;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 300 && !hit; c++) begin
        if (cnt == 8'h37) hit = 1;
        else @(negedge clk);
      end
      chk("rst reached_0x37", int'(hit), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst busy", int'(busy), 0);
      chk("rst bit_valid", int'(bit_valid), 0);
      chk("rst result", int'(result), 0);
      chk("rst done", int'(done), 0);
      chk("rst bp", int'(bp), 8'hFF);
      chk("rst cnt", int'(cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst no_done", int'(done), 0);
      run("post_rst", 4'd4, 8'hB7, 0, 0, 16, 11, 8'hB0, 1'b0, 8'h0F);
      after_done("post_rst", 8'hB0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sc_sng_ctrl.md
Name: sc_sng_ctrl

Overview:
- Stochastic number generator controller that sits directly downstream of the bypass counter: drives the counter's `bp` mask and consumes its `cnt`/`ovf`.
- Compares a captured operand against `cnt` to emit a unipolar SC bitstream of 2^P bits, where P is a programmable precision.
- Supports early termination and returns the ones count as a binary estimate.
- The counter is frozen at zero between runs by driving `bp` all-ones.

Parameters:
- WIDTH, 8, operand/counter width; must match the attached bypass counter.
- PW, $clog2(WIDTH+1), width of precision input.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset, shared with the bypass counter
- start  input  1  request a run; accepted only in IDLE
- x  input  WIDTH  operand, captured on accepted start
- prec  input  PW  precision P (MSBs used), captured on accepted start
- abort  input  1  early-termination request, honoured in RUN only
- cnt  input  WIDTH  bypass counter value
- ovf  input  1  bypass counter overflow (combinational)
- bp  output  WIDTH  bypass mask to counter
- busy  output  1  high in RUN and DRAIN
- bit_valid  output  1  stream bit valid
- bit_out  output  1  stream bit
- done  output  1  one-cycle pulse at end of run
- aborted  output  1  qualifies done; held with result
- result  output  WIDTH  estimate; held until next accepted start

Behaviour:
- Reset: state IDLE; x_q, P_q, ones cleared; done=0, aborted=0, result=0, busy=0, bit_valid=0; bp all-ones.
- Precision rule: prec==0 or prec>WIDTH → P=WIDTH.
- mask = low (WIDTH−P) bits set. x_q = x & ~mask, registered on start.
- IDLE:
  - bp all-ones, which holds cnt frozen.
  - start=1 → capture x_q and P_q, clear ones, clear aborted → RUN.
  - done, aborted and result keep their previous values.
- RUN:
  - bp = mask; counter steps by 2^(WIDTH−P) from 0.
  - bit_valid=1; bit_out = (x_q > cnt), unsigned, combinational from cnt.
  - ones += bit_out each cycle.
  - ovf=1 ends the run: that bit is the last and is counted; the counter wraps to 0 at that edge; next state IDLE.
  - Otherwise abort=1: the bit in that cycle is valid and counted; next state DRAIN.
  - ovf and abort in the same cycle: treated as normal completion, aborted=0.
- DRAIN:
  - bp = mask; bit_valid=0; ones frozen.
  - On ovf → IDLE; the counter is back at 0.
- Completion: the cycle after the RUN→IDLE or DRAIN→IDLE transition has
  - done=1 for exactly one cycle;
  - result = ones << (WIDTH−P_q), truncated to WIDTH;
  - aborted = 1 if exited via DRAIN.
- Ones counter: WIDTH bits; maximum 2^P−1, so it cannot overflow.
- Full-length run: 2^P bit_valid cycles; done arrives one cycle after the last bit.
- start while busy or in the done cycle's IDLE state: start is ignored only while busy. Start in the done cycle is accepted and clears aborted.
- Invariant: cnt==0 whenever state is IDLE; checked by assertion.
- Reset mid-operation: immediate return to reset values; counter also returns to 0; no done pulse.

Test Plan:
- WIDTH=8, prec=8, x=0xB4 → 256 bit_valid cycles, 180 ones, cnt 0x00..0xFF; done one cycle after the last bit; result=0xB4, aborted=0.
- prec=4, x=0xB7 → bp=0x0F; cnt steps 0x00,0x10..0xF0; 16 bits with the first 11 high; result=0xB0.
- Extremes, prec=8:
  - x=0x00 → 256 zeros, result=0.
  - x=0xFF → 255 ones with the final bit low, result=0xFF.
  - prec=0 behaves as prec=8.
- prec=8, x=0x80, abort asserted on the 10th RUN cycle → 10 valid ones, then bit_valid=0 until ovf; done with aborted=1, result=10; cnt==0 after; an immediate new start with x=0x40, prec=2 → result=0x40.
- start pulsed mid-RUN with different x → ignored; the original result is returned. Abort asserted in IDLE → no effect.
- rst_n asserted asynchronously mid-RUN at cnt=0x37 → outputs and state return to reset values immediately; a subsequent run is correct from cnt=0.
